// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the buffered N-channel merge stage.
package mux_pipe_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Channel index width; a single bit even when there is only one channel.
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_WIDTH = 128;
    localparam int DEF_NCH   = 4;
    localparam int DEF_CW    = cw_of(DEF_NCH);

    typedef struct packed {
        logic [DEF_CW-1:0]    chan;
        logic [DEF_WIDTH-1:0] payload;
    } beat_t;

endpackage

// File: rtl/mux_pipe_arb_fifo_n.sv
// Per-channel circular buffer with enq/deq ports and a head-of-queue output.
module fifo_n #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enq_ena_i,
    input  logic [WIDTH-1:0] enq_v_i,
    output logic             enq_rdy_o,
    input  logic             deq_ena_i,
    output logic [WIDTH-1:0] first_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic             full, enq_acc, deq_acc;

    // No bypass: a full buffer refuses input even while it is being drained.
    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign enq_rdy_o = ~full;
    assign enq_acc   = enq_ena_i & ~full;
    assign deq_acc   = deq_ena_i & ~empty_o;
    assign first_o   = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_acc) tail_d = tail_q + 1'b1;
        if (deq_acc) head_d = head_q + 1'b1;
        case ({enq_acc, deq_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_acc) mem_q[tail_q] <= enq_v_i;
    end

endmodule

// File: rtl/mux_pipe_arb.sv
// Buffered N-channel merge: per-channel FIFOs feeding one output enq port,
// arbitrated round-robin or fixed-priority, each beat tagged with its channel.
module mux_pipe_arb
    import mux_pipe_pkg::*;
#(
    parameter int  WIDTH = 128,
    parameter int  NCH   = 4,
    parameter int  DEPTH = 4,
    parameter int  MODE  = MODE_RR,
    localparam int CW    = cw_of(NCH)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NCH-1:0]       in_enq__ENA,
    input  logic [NCH*WIDTH-1:0] in_enq_v,
    output logic [NCH-1:0]       in_enq__RDY,
    output logic                 out_enq__ENA,
    output logic [WIDTH-1:0]     out_enq_v,
    output logic [CW-1:0]        out_enq_chan,
    input  logic                 out_enq__RDY
);

    logic [NCH-1:0]   req, empty, deq;
    logic [WIDTH-1:0] head [NCH];
    logic [CW-1:0]    last_q, last_d, grant, off;
    logic [CW:0]      start, sum;
    logic [2*NCH-1:0] req2;
    logic [NCH-1:0]   rot;
    logic             any_req, xfer;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fifo_n #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk_i    (CLK),
            .rst_ni   (nRST),
            .enq_ena_i(in_enq__ENA[i]),
            .enq_v_i  (in_enq_v[i*WIDTH +: WIDTH]),
            .enq_rdy_o(in_enq__RDY[i]),
            .deq_ena_i(deq[i]),
            .first_o  (head[i]),
            .empty_o  (empty[i])
        );
        assign req[i] = ~empty[i];
        assign deq[i] = xfer && (grant == CW'(i));
    end

    // Rotate req so the search origin lands at bit 0, pick the lowest set
    // bit, then rotate the offset back into a channel index.
    always_comb begin
        start = '0;
        if (MODE == MODE_RR && last_q != CW'(NCH-1)) start = {1'b0, last_q} + 1'b1;
        req2 = {req, req} >> start;
        rot  = req2[NCH-1:0];
        off  = '0;
        for (int j = NCH-1; j >= 0; j--) begin
            if (rot[j]) off = CW'(j);
        end
        sum = start + {1'b0, off};
        if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
        grant = sum[CW-1:0];
    end

    assign any_req      = |req;
    assign xfer         = out_enq__RDY & any_req;
    assign out_enq__ENA = xfer;
    assign out_enq_v    = any_req ? head[grant] : '0;
    assign out_enq_chan = any_req ? grant : '0;

    // last only moves on a real transfer, keeping the grant steady under stall.
    assign last_d = xfer ? grant : last_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last_q <= CW'(NCH-1);
        else       last_q <= last_d;
    end

endmodule

// File: tb/tb_mux_pipe_arb.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus.
module tb_mux_pipe_arb;
    import mux_pipe_pkg::*;

    localparam int WIDTH = DEF_WIDTH;
    localparam int NCH   = DEF_NCH;
    localparam int DEPTH = 4;
    localparam int CW    = DEF_CW;
    localparam int BW    = $bits(beat_t);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       enq_ena = '0;
    logic [NCH*WIDTH-1:0] enq_v = '0;
    logic                 out_rdy = 1'b0;

    logic [NCH-1:0]   rdy_rr, rdy_fx;
    logic             ena_rr, ena_fx;
    logic [WIDTH-1:0] v_rr, v_fx;
    logic [CW-1:0]    chan_rr, chan_fx;

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] exp_rr_q[$];
    logic [BW-1:0] exp_fx_q[$];

    mux_pipe_arb #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .MODE(MODE_RR)) dut_rr (
        .CLK(clk), .nRST(rst_n),
        .in_enq__ENA(enq_ena), .in_enq_v(enq_v), .in_enq__RDY(rdy_rr),
        .out_enq__ENA(ena_rr), .out_enq_v(v_rr), .out_enq_chan(chan_rr),
        .out_enq__RDY(out_rdy)
    );

    mux_pipe_arb #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .MODE(MODE_FIXED)) dut_fx (
        .CLK(clk), .nRST(rst_n),
        .in_enq__ENA(enq_ena), .in_enq_v(enq_v), .in_enq__RDY(rdy_fx),
        .out_enq__ENA(ena_fx), .out_enq_v(v_fx), .out_enq_chan(chan_fx),
        .out_enq__RDY(out_rdy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int ch, input logic [WIDTH-1:0] d);
        beat_t b;
        b.chan    = CW'(ch);
        b.payload = d;
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ena_rr) begin
                if (exp_rr_q.size() == 0) check("spurious_rr", BW'({chan_rr, v_rr}), '0);
                else check("beat_rr", {chan_rr, v_rr}, exp_rr_q.pop_front());
            end
            if (ena_fx) begin
                if (exp_fx_q.size() == 0) check("spurious_fx", BW'({chan_fx, v_fx}), '0);
                else check("beat_fx", {chan_fx, v_fx}, exp_fx_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        enq_ena = '0;
        out_rdy = 1'b0;
        repeat (3) tick();
        exp_rr_q.delete();
        exp_fx_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic enq(input int ch, input logic [WIDTH-1:0] d);
        check("enq_rdy_rr", BW'(rdy_rr[ch]), BW'(1));
        check("enq_rdy_fx", BW'(rdy_fx[ch]), BW'(1));
        enq_ena[ch] = 1'b1;
        enq_v[ch*WIDTH +: WIDTH] = d;
        tick();
        enq_ena = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (exp_rr_q.size() != 0 || exp_fx_q.size() != 0); i++) tick();
        check("drain_rr", BW'(exp_rr_q.size()), '0);
        check("drain_fx", BW'(exp_fx_q.size()), '0);
    endtask

    // ---------------- tests ----------------
    logic [WIDTH-1:0] d [NCH][2];
    logic [WIDTH-1:0] bp [4];

    initial begin
        // Reset then idle
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_rdy", BW'(rdy_rr), BW'(4'hF));
        check("rst_ena", BW'(ena_rr), '0);
        check("rst_out", BW'({chan_rr, v_rr}), '0);
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            check("idle_rdy", BW'({rdy_rr, rdy_fx}), BW'(8'hFF));
            check("idle_ena", BW'({ena_rr, ena_fx}), '0);
        end

        // Single beat on channel 2
        out_rdy = 1'b1;
        enq_ena[2] = 1'b1;
        enq_v[2*WIDTH +: WIDTH] = WIDTH'(8'hA5);
        exp_rr_q.push_back(mk(2, WIDTH'(8'hA5)));
        exp_fx_q.push_back(mk(2, WIDTH'(8'hA5)));
        #1;
        check("single_no_comb", BW'(ena_rr), '0);
        @(posedge clk);
        #1;
        enq_ena = '0;
        check("single_ena", BW'({ena_rr, ena_fx}), BW'(2'b11));
        check("single_beat_rr", {chan_rr, v_rr}, mk(2, WIDTH'(8'hA5)));
        check("single_beat_fx", {chan_fx, v_fx}, mk(2, WIDTH'(8'hA5)));
        tick();
        check("single_idle_ena", BW'({ena_rr, ena_fx}), '0);
        check("single_idle_out", BW'({chan_rr, v_rr}), '0);
        wait_drain();

        // Two beats per channel: round-robin interleaves, fixed drains by index
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < NCH; ch++) begin
                d[ch][k] = rnd_word();
                enq(ch, d[ch][k]);
            end
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < NCH; ch++) exp_rr_q.push_back(mk(ch, d[ch][k]));
        for (int ch = 0; ch < NCH; ch++)
            for (int k = 0; k < 2; k++) exp_fx_q.push_back(mk(ch, d[ch][k]));
        out_rdy = 1'b1;
        for (int i = 0; i < 2*NCH; i++) begin
            #2;
            check("stream_ena", BW'({ena_rr, ena_fx}), BW'(2'b11));
            @(posedge clk);
        end
        #2;
        check("stream_end_ena", BW'({ena_rr, ena_fx}), '0);
        wait_drain();

        // Backpressure until channel 1 fills, then release
        do_reset();
        for (int b = 0; b < DEPTH; b++) begin
            bp[b] = rnd_word();
            enq(1, bp[b]);
            exp_rr_q.push_back(mk(1, bp[b]));
            exp_fx_q.push_back(mk(1, bp[b]));
            check("fill_rdy", BW'(rdy_rr[1]), BW'(b < DEPTH-1));
        end
        repeat (3) begin
            check("stall_ena", BW'({ena_rr, ena_fx}), '0);
            check("stall_hold_rr", {chan_rr, v_rr}, exp_rr_q[0]);
            check("stall_hold_fx", {chan_fx, v_fx}, exp_fx_q[0]);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        check("release_ena", BW'({ena_rr, ena_fx}), BW'(2'b11));
        check("release_no_bypass", BW'(rdy_rr[1]), '0);
        @(posedge clk);
        #1;
        check("release_rdy", BW'({rdy_rr[1], rdy_fx[1]}), BW'(2'b11));
        wait_drain();
        check("release_idle", BW'({ena_rr, ena_fx}), '0);

        // Asynchronous reset with beats still buffered
        do_reset();
        for (int b = 0; b < 3; b++) enq(0, rnd_word());
        out_rdy = 1'b1;
        #1;
        check("pre_rst_ena", BW'(ena_rr), BW'(1));
        #1;
        rst_n = 1'b0;
        exp_rr_q.delete();
        exp_fx_q.delete();
        #1;
        check("async_rst_ena", BW'({ena_rr, ena_fx}), '0);
        check("async_rst_rdy", BW'({rdy_rr, rdy_fx}), BW'(8'hFF));
        check("async_rst_out", BW'({chan_rr, v_rr}), '0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("post_rst_ena", BW'({ena_rr, ena_fx}), '0);
        end
        exp_rr_q.push_back(mk(3, WIDTH'(16'h5A5A)));
        exp_fx_q.push_back(mk(3, WIDTH'(16'h5A5A)));
        enq(3, WIDTH'(16'h5A5A));
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
